// File: rtl/intersect_monitor_pkg.sv
// Shared types for the intersect_monitor checker.
// States, failure causes and the default gap bound.
package intersect_monitor_pkg;

    localparam int MAX_GAP_DEFAULT = 30;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FIRST  = 3'd1,
        GAP    = 3'd2,
        TAIL_B = 3'd3,
        TAIL_C = 3'd4,
        TAIL_D = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        FC_NONE       = 3'd0,
        FC_NO_B_START = 3'd1,
        FC_C_DROP     = 3'd2,
        FC_NO_D_END   = 3'd3,
        FC_TAIL_B     = 3'd4,
        FC_TAIL_C     = 3'd5,
        FC_TAIL_D     = 3'd6,
        FC_TIMEOUT    = 3'd7
    } fail_code_t;

endpackage

// File: rtl/intersect_monitor_sat_counter.sv
// Saturating up-counter used for verdict statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = 1;
    localparam logic [WIDTH-1:0] TOP = '1;

    // count up on inc, stick at the top value
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && count != TOP) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/intersect_monitor.sv
// Checker for A |=> ((B ##1 !B[*] ##1 B) intersect (C[*] ##1 D))
// ##1 B ##1 C ##1 D, one attempt at a time, registered verdicts.
module intersect_monitor
    import intersect_monitor_pkg::*;
#(
    parameter int MAX_GAP = MAX_GAP_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic       busy,
    output logic       pass,
    output logic       fail,
    output logic [2:0] fail_code,
    output logic [4:0] gap_len,
    output logic       overlap,
    output logic [7:0] pass_count,
    output logic [7:0] fail_count
);

    localparam logic [4:0] K_MAX = 5'(MAX_GAP);

    state_t     state;
    state_t     state_n;
    logic [4:0] k;
    logic [4:0] k_n;
    logic       pass_n;
    logic       fail_n;
    fail_code_t code_n;
    logic       gap_load;

    // state and gap counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
        end
    end

    // next state, gap count and verdict decision
    always_comb begin
        state_n  = state;
        k_n      = k;
        pass_n   = 1'b0;
        fail_n   = 1'b0;
        code_n   = FC_NONE;
        gap_load = 1'b0;
        unique case (state)
            IDLE: begin
                if (a) begin
                    state_n = FIRST;
                    k_n     = '0;
                end
            end
            FIRST: begin
                if (!b) begin
                    fail_n = 1'b1;
                    code_n = FC_NO_B_START;
                end else if (!c) begin
                    fail_n = 1'b1;
                    code_n = FC_C_DROP;
                end else begin
                    state_n = GAP;
                    k_n     = '0;
                end
            end
            GAP: begin
                if (b) begin
                    if (d) begin
                        state_n  = TAIL_B;
                        gap_load = 1'b1;
                    end else begin
                        fail_n = 1'b1;
                        code_n = FC_NO_D_END;
                    end
                end else if (!c) begin
                    fail_n = 1'b1;
                    code_n = FC_C_DROP;
                end else if (k == K_MAX) begin
                    fail_n = 1'b1;
                    code_n = FC_TIMEOUT;
                end else begin
                    k_n = k + 5'd1;
                end
            end
            TAIL_B: begin
                if (b) begin
                    state_n = TAIL_C;
                end else begin
                    fail_n = 1'b1;
                    code_n = FC_TAIL_B;
                end
            end
            TAIL_C: begin
                if (c) begin
                    state_n = TAIL_D;
                end else begin
                    fail_n = 1'b1;
                    code_n = FC_TAIL_C;
                end
            end
            TAIL_D: begin
                if (d) begin
                    pass_n = 1'b1;
                end else begin
                    fail_n = 1'b1;
                    code_n = FC_TAIL_D;
                end
            end
            default: state_n = IDLE;
        endcase
        if (pass_n || fail_n) begin
            state_n = IDLE;
        end
    end

    // registered verdict, cause, gap length and overlap pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            pass      <= 1'b0;
            fail      <= 1'b0;
            overlap   <= 1'b0;
            fail_code <= '0;
            gap_len   <= '0;
        end else begin
            pass    <= pass_n;
            fail    <= fail_n;
            overlap <= a && (state != IDLE);
            if (fail_n) begin
                fail_code <= code_n;
            end
            if (gap_load) begin
                gap_len <= k;
            end
        end
    end

    // busy reflects any attempt in flight
    always_comb begin
        busy = (state != IDLE);
    end

    sat_counter #(.WIDTH(8)) u_pass_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (pass),
        .count (pass_count)
    );

    sat_counter #(.WIDTH(8)) u_fail_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (fail),
        .count (fail_count)
    );

endmodule

// File: tb/tb_intersect_monitor.sv
// Scoreboard bench for intersect_monitor: two instances
// (MAX_GAP 30 and 3) share stimulus; a trace model predicts outputs.
module tb_intersect_monitor;

    localparam int L = 4096;

    typedef struct {
        int         cyc;
        bit         p;
        bit         f;
        bit         o;
        logic [2:0] code;
        logic [4:0] gap;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic a = 1'b0;
    logic b = 1'b0;
    logic c = 1'b0;
    logic d = 1'b0;

    logic [1:0] busy_o;
    logic [1:0] pass_o;
    logic [1:0] fail_o;
    logic [1:0] ovl_o;
    logic [2:0] code_o [2];
    logic [4:0] gap_o [2];
    logic [7:0] pc_o [2];
    logic [7:0] fc_o [2];

    bit tra [L];
    bit trb [L];
    bit trc [L];
    bit trd [L];
    bit trr [L];
    int len;

    bit         ep [2][L];
    bit         ef [2][L];
    bit         eo [2][L];
    bit         ebusy [2][L];
    logic [2:0] ecode [2][L];
    logic [4:0] egap [2][L];

    ev_t q0[$];
    ev_t q1[$];

    int checks = 0;
    int failures = 0;
    int cur = 0;
    bit active = 1'b0;
    int cp [2];
    int cf [2];
    int hc [2];

    always #5 clock = ~clock;

    intersect_monitor dut0 (
        .clock(clock), .reset(reset),
        .a(a), .b(b), .c(c), .d(d),
        .busy(busy_o[0]), .pass(pass_o[0]), .fail(fail_o[0]),
        .fail_code(code_o[0]), .gap_len(gap_o[0]),
        .overlap(ovl_o[0]),
        .pass_count(pc_o[0]), .fail_count(fc_o[0])
    );

    intersect_monitor #(.MAX_GAP(3)) dut1 (
        .clock(clock), .reset(reset),
        .a(a), .b(b), .c(c), .d(d),
        .busy(busy_o[1]), .pass(pass_o[1]), .fail(fail_o[1]),
        .fail_code(code_o[1]), .gap_len(gap_o[1]),
        .overlap(ovl_o[1]),
        .pass_count(pc_o[1]), .fail_count(fc_o[1])
    );

    function automatic bit g(int kind, int i);
        if (i < 0 || i >= len) return 1'b0;
        case (kind)
            0: return tra[i];
            1: return trb[i];
            2: return trc[i];
            3: return trd[i];
            default: return trr[i];
        endcase
    endfunction

    // Outcome of an attempt whose A is at cycle t:
    // decision cycle, fail code (0 = match), and !B count.
    task automatic eval(input int t, input int mg, output int dec,
                        output logic [2:0] code, output logic [4:0] gap);
        int j;
        int kk;
        code = 3'd0;
        gap = 5'd0;
        if (!g(1, t + 1)) begin dec = t + 1; code = 3'd1; return; end
        if (!g(2, t + 1)) begin dec = t + 1; code = 3'd2; return; end
        j = t + 2;
        kk = 0;
        while (!g(1, j)) begin
            if (!g(2, j)) begin dec = j; code = 3'd2; return; end
            if (kk == mg) begin dec = j; code = 3'd7; return; end
            kk++;
            j++;
        end
        if (!g(3, j)) begin dec = j; code = 3'd3; return; end
        gap = kk[4:0];
        if (!g(1, j + 1)) begin dec = j + 1; code = 3'd4; return; end
        if (!g(2, j + 2)) begin dec = j + 2; code = 3'd5; return; end
        if (!g(3, j + 3)) begin dec = j + 3; code = 3'd6; return; end
        dec = j + 3;
    endtask

    task automatic model(input int inst);
        int mg;
        int i;
        int dec;
        int r;
        logic [2:0] code;
        logic [4:0] gap;
        mg = (inst == 0) ? 30 : 3;
        for (int n = 0; n < L; n++) begin
            ep[inst][n] = 0; ef[inst][n] = 0; eo[inst][n] = 0;
            ebusy[inst][n] = 0; ecode[inst][n] = 0; egap[inst][n] = 0;
        end
        i = 0;
        while (i < len) begin
            if (g(4, i) || !g(0, i)) begin
                i++;
                continue;
            end
            eval(i, mg, dec, code, gap);
            r = -1;
            for (int j = i + 1; j <= dec; j++)
                if (r < 0 && g(4, j)) r = j;
            if (r >= 0) begin
                for (int j = i + 1; j <= r; j++) begin
                    ebusy[inst][j] = 1;
                    if (j < r && g(0, j)) eo[inst][j + 1] = 1;
                end
                i = r;
            end else begin
                for (int j = i + 1; j <= dec; j++) begin
                    ebusy[inst][j] = 1;
                    if (g(0, j)) eo[inst][j + 1] = 1;
                end
                if (code == 3'd0) begin
                    ep[inst][dec + 1] = 1;
                    egap[inst][dec + 1] = gap;
                end else begin
                    ef[inst][dec + 1] = 1;
                    ecode[inst][dec + 1] = code;
                end
                i = dec + 1;
            end
        end
    endtask

    task automatic chk(input string nm, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0d exp=%0d", nm, i, cur, act, exp);
        end
    endtask

    task automatic q_peek(input int i, output bit ok, output ev_t e);
        ok = 0;
        e = '{default: 0};
        if (i == 0 && q0.size() > 0) begin ok = 1; e = q0[0]; end
        if (i == 1 && q1.size() > 0) begin ok = 1; e = q1[0]; end
    endtask

    task automatic q_pop(input int i);
        if (i == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endtask

    task automatic monitor_inst(input int i);
        int n;
        bit ok;
        ev_t e;
        n = cur;
        if (trr[n - 1]) begin
            cp[i] = 0; cf[i] = 0; hc[i] = 0;
        end else begin
            if (ep[i][n - 1] && cp[i] < 255) cp[i]++;
            if (ef[i][n - 1] && cf[i] < 255) cf[i]++;
        end
        if (ef[i][n]) hc[i] = int'(ecode[i][n]);
        chk("busy", i, int'(busy_o[i]), int'(ebusy[i][n]));
        chk("pass_count", i, int'(pc_o[i]), cp[i]);
        chk("fail_count", i, int'(fc_o[i]), cf[i]);
        chk("fail_code_held", i, int'(code_o[i]), hc[i]);
        chk("pass_and_fail", i, int'(pass_o[i] & fail_o[i]), 0);
        q_peek(i, ok, e);
        while (ok && e.cyc < n) begin
            checks++;
            failures++;
            $display("FAIL missed_event inst=%0d cyc=%0d got=none exp_cyc=%0d", i, n, e.cyc);
            q_pop(i);
            q_peek(i, ok, e);
        end
        if (ok && e.cyc == n) begin
            q_pop(i);
            chk("pass", i, int'(pass_o[i]), int'(e.p));
            chk("fail", i, int'(fail_o[i]), int'(e.f));
            chk("overlap", i, int'(ovl_o[i]), int'(e.o));
            if (e.f) chk("fail_code", i, int'(code_o[i]), int'(e.code));
            if (e.p) chk("gap_len", i, int'(gap_o[i]), int'(e.gap));
        end else if (pass_o[i] || fail_o[i] || ovl_o[i]) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event inst=%0d cyc=%0d got=p%0d/f%0d/o%0d exp=none",
                     i, n, pass_o[i], fail_o[i], ovl_o[i]);
        end
    endtask

    // compare every cycle of an active phase, away from the sampling edge
    always @(negedge clock) begin
        if (active && cur > 0) begin
            for (int i = 0; i < 2; i++) monitor_inst(i);
        end
    end

    task automatic clear_trace(input int n);
        len = n;
        for (int i = 0; i < L; i++) begin
            tra[i] = 0; trb[i] = 0; trc[i] = 0; trd[i] = 0; trr[i] = 0;
        end
        trr[0] = 1;
    endtask

    task automatic setr(input int kind, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            case (kind)
                0: tra[i] = 1;
                1: trb[i] = 1;
                2: trc[i] = 1;
                3: trd[i] = 1;
                default: trr[i] = 1;
            endcase
        end
    endtask

    task automatic base_030();
        clear_trace(30);
        setr(0, 1, 1);
        setr(1, 2, 2); setr(1, 13, 14);
        setr(2, 2, 12); setr(2, 15, 15);
        setr(3, 13, 13); setr(3, 16, 16);
    endtask

    task automatic run_phase();
        ev_t e;
        model(0);
        model(1);
        @(posedge clock);
        #1;
        cur = 0;
        active = 1;
        for (int n = 0; n < len; n++) begin
            cur = n;
            reset = trr[n]; a = tra[n]; b = trb[n]; c = trc[n]; d = trd[n];
            for (int i = 0; i < 2; i++) begin
                if (ep[i][n] || ef[i][n] || eo[i][n]) begin
                    e.cyc = n; e.p = ep[i][n]; e.f = ef[i][n]; e.o = eo[i][n];
                    e.code = ecode[i][n]; e.gap = egap[i][n];
                    if (i == 0) q0.push_back(e);
                    else q1.push_back(e);
                end
            end
            @(posedge clock);
            #1;
        end
        active = 0;
        reset = 0; a = 0; b = 0; c = 0; d = 0;
        chk("leftover_inst0", 0, q0.size(), 0);
        chk("leftover_inst1", 1, q1.size(), 0);
        q0.delete();
        q1.delete();
    endtask

    task automatic gen_random();
        int p;
        int k;
        int pos;
        clear_trace(3000);
        p = 3;
        while (p < len - 60) begin
            k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 33))
                                            : int'($urandom_range(0, 6));
            tra[p] = 1;
            trb[p + 1] = 1;
            setr(2, p + 1, p + k + 1);
            trb[p + k + 2] = 1; trd[p + k + 2] = 1;
            trb[p + k + 3] = 1;
            trc[p + k + 4] = 1;
            trd[p + k + 5] = 1;
            if ($urandom_range(0, 2) == 0) begin
                pos = p + int'($urandom_range(1, k + 5));
                case ($urandom_range(1, 3))
                    1: trb[pos] = !trb[pos];
                    2: trc[pos] = !trc[pos];
                    default: trd[pos] = !trd[pos];
                endcase
            end
            if ($urandom_range(0, 5) == 0)
                tra[p + int'($urandom_range(1, k + 5))] = 1;
            p += int'($urandom_range(k + 2, k + 9));
        end
        trr[$urandom_range(100, len - 100)] = 1;
        trr[$urandom_range(100, len - 100)] = 1;
    endtask

    initial begin
        cp = '{0, 0}; cf = '{0, 0}; hc = '{0, 0};
        // plain match, k=10; a during the reset cycle is ignored
        base_030();
        tra[0] = 1;
        run_phase();
        // B returns without D
        base_030();
        trb[13] = 0; setr(1, 12, 12);
        run_phase();
        // C drops inside the gap, with and without an early D
        base_030();
        trc[12] = 0;
        run_phase();
        base_030();
        trc[12] = 0; setr(3, 12, 12);
        run_phase();
        // tail B missing
        clear_trace(30);
        setr(0, 1, 1);
        setr(1, 2, 2); setr(1, 13, 13); setr(1, 15, 15);
        setr(2, 2, 12); setr(2, 16, 16);
        setr(3, 13, 13); setr(3, 17, 17);
        run_phase();
        // overlapping A, then reset mid-attempt
        base_030();
        setr(0, 5, 5);
        run_phase();
        base_030();
        setr(4, 8, 8);
        run_phase();
        // long gap: timeout on the MAX_GAP=3 instance
        clear_trace(30);
        setr(0, 1, 1);
        setr(1, 2, 2);
        setr(2, 2, 10);
        run_phase();
        // back-to-back failing attempts saturate fail_count
        clear_trace(560);
        for (int t = 1; t < 1 + 2 * 260; t += 2) tra[t] = 1;
        run_phase();
        // randomized traces
        gen_random();
        run_phase();
        gen_random();
        run_phase();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intersect_monitor.md
INTERSECT_MONITOR -- requirements
Module: intersect_monitor

Interface
REQ-001 Parameter MAX_GAP, default 30, maximum count of !B cycles inside one B-sequence; legal range 1..31.
REQ-002 clock  input  1  sole clock; all state updates on posedge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a, b, c, d  input  1 each  sampled trace signals A, B, C, D.
REQ-005 busy  output  1  high whenever the FSM is not IDLE.
REQ-006 pass  output  1  one-cycle pulse; attempt matched.
REQ-007 fail  output  1  one-cycle pulse; attempt failed.
REQ-008 fail_code  output  3  cause of the last failure; held until the next verdict.
REQ-009 gap_len  output  5  k, the !B count of the last completed B-sequence.
REQ-010 overlap  output  1  one-cycle pulse; a was high while busy.
REQ-011 pass_count, fail_count  output  8 each  saturating verdict counters.

Function
REQ-012 The block SHALL check, in synthesizable RTL, A |=> ((B ##1 !B[*] ##1 B) intersect (C[*] ##1 D)) ##1 B ##1 C ##1 D.
- With A at cycle t and k = number of !B cycles, a match requires: B at t+1; !B at t+2..t+k+1; C at t+1..t+k+1; B and D at t+k+2; B at t+k+3; C at t+k+4; D at t+k+5.
REQ-013 FSM states: IDLE, FIRST, GAP, TAIL_B, TAIL_C, TAIL_D.
REQ-014 IDLE: a=1 -> FIRST; otherwise stay in IDLE.
REQ-015 FIRST: b&c -> GAP with k=0; !b -> fail code 1; b&!c -> fail code 2.
REQ-016 GAP with b=1: d=1 -> TAIL_B and gap_len<=k; d=0 -> fail code 3.
REQ-017 GAP with b=0: c=0 -> fail code 2; c=1 and k==MAX_GAP -> fail code 7 (timeout); otherwise k<=k+1 and stay in GAP.
REQ-018 Tail states: TAIL_B needs b, else fail code 4; TAIL_C needs c, else code 5; TAIL_D needs d, else code 6.
- TAIL_D with d=1 -> pass.
REQ-019 Verdict timing: the verdict is registered. pass/fail SHALL assert in the cycle after the deciding sample, and the FSM is in IDLE in that same cycle.
REQ-020 pass and fail SHALL never assert together; fail_code SHALL update only when fail asserts.
REQ-021 Only one attempt is tracked at a time. a=1 sampled in any non-IDLE state SHALL produce an overlap pulse next cycle and SHALL NOT start a new attempt.
REQ-022 a=1 in the IDLE cycle in which a verdict pulse is shown SHALL start a new attempt normally.
REQ-023 Counter updates: each pass pulse increments pass_count and each fail pulse increments fail_count. Both counters saturate at 255 with no wrap.
REQ-024 k SHALL be 5 bits; no arithmetic SHALL overflow given MAX_GAP <= 31.

Reset
REQ-025 Reset SHALL be synchronous and active-high, and SHALL take priority over all inputs, including a=1 in the same cycle.
REQ-026 Reset values: state IDLE; busy, pass, fail and overlap 0; fail_code 0; gap_len 0; k 0; pass_count and fail_count 0.
REQ-027 Reset mid-attempt SHALL abandon the attempt with no verdict pulse.

Structure
REQ-028 Package intersect_monitor_pkg SHALL hold:
- the state enum;
- the fail-code enum: NONE=0, NO_B_START=1, C_DROP=2, NO_D_END=3, TAIL_B=4, TAIL_C=5, TAIL_D=6, TIMEOUT=7;
- the MAX_GAP default.
REQ-029 The two counters SHALL be instances of one sub-module, sat_counter (8-bit, synchronous reset, inc input).

Verification
Cycle index = trace position; all traces idle except where shown; reset is applied for the first cycle.
REQ-030 a@1; b@2,13,14; c@2..12,15; d@13,16 -> pass at 17; gap_len=10; pass_count=1.
REQ-031 Same as REQ-030 but b@2,12,14 -> fail at 13, code 3.
REQ-032 Same as REQ-030 but c@2..11,15 -> fail at 13, code 2; same result with d@12,16 added.
REQ-033 a@1; b@2,13,15; c@2..12,16; d@13,17 -> fail at 15, code 4.
REQ-034 a@1,5 with the REQ-030 traces -> overlap at 6, then pass at 17; a@1 then reset@8 -> no verdict pulse, busy=0 at 9.
REQ-035 MAX_GAP=3; a@1; b@2; c@2..10 -> fail at 7, code 7; 256 consecutive failing attempts -> fail_count=255.
